// File: rtl/ahbl_dma_master.sv
// Single-channel AHB-Lite DMA master: copies len beats of byte/half/word from src to dst.
// Optional DMA_FILL_EN adds a fill mode that writes a constant pattern with no read phases.
module ahbl_dma_master #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [1:0]       size,
`ifdef DMA_FILL_EN
  input  logic             fill,
  input  logic [31:0]      fill_data,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  input  logic [31:0]      HRDATA
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_D,
    S_WR_A,
    S_WR_D,
    S_FIN
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_src, w_src_nxt;
  logic [31:0]      r_dst, w_dst_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  logic [1:0]       r_size, w_size_nxt;
  logic [31:0]      r_data, w_data_nxt;
  logic             r_fill, w_fill_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic [31:0]      r_haddr, w_haddr_nxt;
  logic [1:0]       r_htrans, w_htrans_nxt;
  logic             r_hwrite, w_hwrite_nxt;
  logic [2:0]       r_hsize, w_hsize_nxt;
  logic [31:0]      r_hwdata, w_hwdata_nxt;
  logic [31:0]      w_inc;
  logic             w_fill_req;
  logic [31:0]      w_fill_data;
  logic             w_bad_req;

  function automatic logic f_misaligned(input logic [1:0] a, input logic [1:0] sz);
    logic m;
    case (sz)
      2'd1:    m = a[0];
      2'd2:    m = |a;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Narrow beats are replicated across all byte lanes of HWDATA
  function automatic logic [31:0] f_lanes(input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] r;
    case (sz)
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef DMA_FILL_EN
  assign w_fill_req  = fill;
  assign w_fill_data = fill_data;
`else
  assign w_fill_req  = 1'b0;
  assign w_fill_data = 32'h0;
`endif

  assign w_inc     = 32'd1 << r_size;
  assign w_bad_req = (size == 2'd3) || f_misaligned(dst_addr[1:0], size) ||
                     (!w_fill_req && f_misaligned(src_addr[1:0], size));

  // Next-state and registered-output computation
  always_comb begin
    w_state_nxt  = r_state;
    w_src_nxt    = r_src;
    w_dst_nxt    = r_dst;
    w_rem_nxt    = r_rem;
    w_size_nxt   = r_size;
    w_data_nxt   = r_data;
    w_fill_nxt   = r_fill;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;
    w_haddr_nxt  = r_haddr;
    w_htrans_nxt = r_htrans;
    w_hwrite_nxt = r_hwrite;
    w_hsize_nxt  = r_hsize;
    w_hwdata_nxt = r_hwdata;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_src_nxt   = src_addr;
          w_dst_nxt   = dst_addr;
          w_rem_nxt   = len;
          w_size_nxt  = size;
          w_fill_nxt  = w_fill_req;
          w_data_nxt  = w_fill_data;
          w_err_nxt   = 1'b0;
          if (w_bad_req) begin
            w_err_nxt  = 1'b1;
            w_done_nxt = 1'b1;
          end else if (len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_busy_nxt   = 1'b1;
            w_htrans_nxt = TR_NONSEQ;
            w_hsize_nxt  = {1'b0, size};
            if (w_fill_req) begin
              w_state_nxt  = S_WR_A;
              w_haddr_nxt  = dst_addr;
              w_hwrite_nxt = 1'b1;
            end else begin
              w_state_nxt  = S_RD_A;
              w_haddr_nxt  = src_addr;
              w_hwrite_nxt = 1'b0;
            end
          end
        end
      end

      S_RD_A: begin
        if (HREADY) begin
          w_state_nxt  = S_RD_D;
          w_htrans_nxt = TR_IDLE;
        end
      end

      S_RD_D: begin
        if (HREADY) begin
          if (HRESP) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_FIN;
          end else begin
            w_data_nxt   = HRDATA;
            w_state_nxt  = S_WR_A;
            w_htrans_nxt = TR_NONSEQ;
            w_hwrite_nxt = 1'b1;
            w_haddr_nxt  = r_dst;
          end
        end
      end

      S_WR_A: begin
        if (HREADY) begin
          w_state_nxt  = S_WR_D;
          w_htrans_nxt = TR_IDLE;
          w_hwdata_nxt = f_lanes(r_data, r_size);
        end
      end

      S_WR_D: begin
        if (HREADY) begin
          if (HRESP) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_FIN;
          end else begin
            w_src_nxt = r_src + w_inc;
            w_dst_nxt = r_dst + w_inc;
            w_rem_nxt = r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) begin
              w_state_nxt = S_FIN;
            end else if (r_fill) begin
              w_state_nxt  = S_WR_A;
              w_htrans_nxt = TR_NONSEQ;
              w_hwrite_nxt = 1'b1;
              w_haddr_nxt  = r_dst + w_inc;
            end else begin
              w_state_nxt  = S_RD_A;
              w_htrans_nxt = TR_NONSEQ;
              w_hwrite_nxt = 1'b0;
              w_haddr_nxt  = r_src + w_inc;
            end
          end
        end
      end

      S_FIN: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_htrans_nxt = TR_IDLE;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= S_IDLE;
      r_src    <= 32'h0;
      r_dst    <= 32'h0;
      r_rem    <= '0;
      r_size   <= 2'd0;
      r_data   <= 32'h0;
      r_fill   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_haddr  <= 32'h0;
      r_htrans <= TR_IDLE;
      r_hwrite <= 1'b0;
      r_hsize  <= 3'd0;
      r_hwdata <= 32'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_src    <= w_src_nxt;
      r_dst    <= w_dst_nxt;
      r_rem    <= w_rem_nxt;
      r_size   <= w_size_nxt;
      r_data   <= w_data_nxt;
      r_fill   <= w_fill_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_haddr  <= w_haddr_nxt;
      r_htrans <= w_htrans_nxt;
      r_hwrite <= w_hwrite_nxt;
      r_hsize  <= w_hsize_nxt;
      r_hwdata <= w_hwdata_nxt;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign HADDR  = r_haddr;
  assign HTRANS = r_htrans;
  assign HWRITE = r_hwrite;
  assign HSIZE  = r_hsize;
  assign HWDATA = r_hwdata;

endmodule
